// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered on grant, the ALU runs for one cycle, results are held until consumed.
module alu_share_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [CTRL_W-1:0] req0_op,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [CTRL_W-1:0] req1_op,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [WIDTH-1:0]  resp_result,
  output logic              resp_zero,
  output logic              resp_err,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam logic [CTRL_W-1:0] OP_AND = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] OP_OR  = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] OP_ADD = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] OP_SUB = CTRL_W'(4'b0110);

  state_t state;
  state_t state_next;

  logic prio;
  logic owner;
  logic err_q;
  logic grant0;
  logic grant1;
  logic accept;
  logic done;
  logic legal;

  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;
  logic [CTRL_W-1:0] sel_op;

  // Grants are mutually exclusive: prio only breaks a tie.
  assign grant0 = req0_valid & (~req1_valid | ~prio);
  assign grant1 = req1_valid & (~req0_valid | prio);

  assign sel_a  = grant1 ? req1_a  : req0_a;
  assign sel_b  = grant1 ? req1_b  : req0_b;
  assign sel_op = grant1 ? req1_op : req0_op;

  always_comb begin
    legal = 1'b0;
    unique case (1'b1)
      sel_op == OP_AND: legal = 1'b1;
      sel_op == OP_OR:  legal = 1'b1;
      sel_op == OP_ADD: legal = 1'b1;
      sel_op == OP_SUB: legal = 1'b1;
      default:          legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    done        = 1'b0;
    unique case (state)
      IDLE: begin
        req0_ready = grant0 & reset_n;
        req1_ready = grant1 & reset_n;
        if (grant0 | grant1) state_next = EXEC;
      end
      EXEC: state_next = RESP;
      RESP: begin
        resp0_valid = ~owner;
        resp1_valid = owner;
        done = owner ? resp1_ready : resp0_ready;
        if (done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = req0_ready | req1_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio        <= 1'b0;
      owner       <= 1'b0;
      err_q       <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_ctrl    <= OP_ADD;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      if (accept) begin
        owner    <= grant1;
        alu_a    <= sel_a;
        alu_b    <= sel_b;
        // Illegal codes still drive a harmless ADD into the ALU.
        alu_ctrl <= legal ? sel_op : OP_ADD;
        err_q    <= ~legal;
      end
      if (state == EXEC) begin
        resp_result <= err_q ? '0 : alu_result;
        resp_zero   <= ~err_q & alu_zero;
        resp_err    <= err_q;
      end
      if (done) prio <= ~owner;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural ALU.
// Expected responses are queued at accept and compared at handshake.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic [3:0]  req0_op;
  logic        resp0_valid, resp0_ready;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic [3:0]  req1_op;
  logic        resp1_valid, resp1_ready;
  logic [31:0] resp_result;
  logic        resp_zero, resp_err;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_zero;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        z;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(32), .CTRL_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(resp_result), .resp_zero(resp_zero),
    .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  always_comb begin
    alu_result = alu_a + alu_b;
    case (alu_ctrl)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      default: alu_result = alu_a + alu_b;
    endcase
    alu_zero = (alu_ctrl == 4'b0110) && (alu_a == alu_b);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h",
                  tag, got, exp);
  endtask

  function automatic exp_t model(input logic id,
                                 input logic [31:0] a,
                                 input logic [31:0] b,
                                 input logic [3:0] op);
    exp_t e;
    e.id = id;
    e.z = 1'b0;
    e.err = 1'b0;
    case (op)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0010: e.res = a + b;
      4'b0110: begin
        e.res = a - b;
        e.z = (a == b);
      end
      default: begin
        e.res = '0;
        e.err = 1'b1;
      end
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      if (req0_ready)
        sb.push_back(model(1'b0, req0_a, req0_b, req0_op));
      if (req1_ready)
        sb.push_back(model(1'b1, req1_a, req1_b, req1_op));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (resp0_valid && resp1_valid) check("one_owner", 1, 0);
      if ((resp0_valid && resp0_ready) ||
          (resp1_valid && resp1_ready)) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 1, 0);
        end else begin
          e = sb.pop_front();
          check("owner", 32'(resp1_valid), 32'(e.id));
          check("result", resp_result, e.res);
          check("zero", 32'(resp_zero), 32'(e.z));
          check("err", 32'(resp_err), 32'(e.err));
        end
      end
    end
  end

  task automatic wait_grant(input int budget, output int id);
    id = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (req0_ready) begin id = 0; return; end
      if (req1_ready) begin id = 1; return; end
    end
    check("grant_timeout", 1, 0);
  endtask

  task automatic issue(input int id, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] op);
    int g;
    if (id == 0) begin
      req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
    end
    wait_grant(10, g);
    check("grant", g, id);
    @(posedge clk); #1;
    if (id == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int g;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    resp0_ready = 1; resp1_ready = 1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_result", resp_result, 0);
    check("rst_zero", 32'(resp_zero), 0);
    check("rst_err", 32'(resp_err), 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_ctrl", 32'(alu_ctrl), 2);
    check("rst_valid", 32'({resp1_valid, resp0_valid}), 0);
    check("rst_ready", 32'({req1_ready, req0_ready}), 0);
    @(posedge clk); #1;

    // single ADD and its latency
    issue(0, 5, 7, 4'b0010);
    @(negedge clk);
    check("add_exec_valid", 32'(resp0_valid), 0);
    check("add_exec_alu_a", alu_a, 5);
    check("add_exec_ctrl", 32'(alu_ctrl), 2);
    @(negedge clk);
    check("add_lat_valid", 32'(resp0_valid), 1);
    drain();

    issue(1, 32'h1234, 32'h1234, 4'b0110);
    drain();
    issue(1, 0, 1, 4'b0110);
    drain();

    // continuous contention
    req0_a = 32'hF0; req0_b = 32'h3C; req0_op = 4'b0000;
    req1_a = 32'hF0; req1_b = 32'h0F; req1_op = 4'b0001;
    req0_valid = 1; req1_valid = 1;
    for (int k = 0; k < 4; k++) begin
      wait_grant(10, g);
      check("rr_order", g, k % 2);
      @(posedge clk); #1;
    end
    req0_valid = 0; req1_valid = 0;
    drain();

    // backpressure on requester 0
    resp0_ready = 0;
    req0_a = 3; req0_b = 4; req0_op = 4'b0010;
    req1_a = 8; req1_b = 8; req1_op = 4'b0110;
    req0_valid = 1; req1_valid = 1;
    wait_grant(10, g);
    check("bp_grant", g, 0);
    @(posedge clk); #1;
    req0_valid = 0;
    for (int i = 0; i < 10 && !resp0_valid; i++) @(negedge clk);
    check("bp_resp_seen", 32'(resp0_valid), 1);
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", 32'(resp0_valid), 1);
      check("bp_result", resp_result, 7);
      check("bp_req1_ready", 32'(req1_ready), 0);
    end
    @(posedge clk); #1;
    resp0_ready = 1;
    @(negedge clk);
    @(negedge clk);
    check("bp_next_grant", 32'(req1_ready), 1);
    @(posedge clk); #1;
    req1_valid = 0;
    drain();

    // illegal op forces ADD into the ALU
    issue(0, 9, 3, 4'b0101);
    @(negedge clk);
    check("ill_ctrl", 32'(alu_ctrl), 2);
    check("ill_alu_a", alu_a, 9);
    drain();

    // async reset during EXEC
    issue(0, 1, 1, 4'b0010);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", 32'({resp1_valid, resp0_valid}), 0);
    check("arst_alu_ctrl", 32'(alu_ctrl), 2);
    check("arst_alu_a", alu_a, 0);
    check("arst_err", 32'(resp_err), 0);
    check("arst_result", resp_result, 0);
    sb.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("arst_noresp", 32'({resp1_valid, resp0_valid}), 0);
    end
    @(posedge clk); #1;
    req0_a = 32'hFF; req0_b = 32'h0F; req0_op = 4'b0000;
    req1_a = 32'h10; req1_b = 32'h01; req1_op = 4'b0001;
    req0_valid = 1; req1_valid = 1;
    wait_grant(10, g);
    check("arst_prio", g, 0);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one ALU_unit instance between two requesters, e.g. the main execute path and a branch/address helper.
- Arbitrates round-robin, registers operands, drives the ALU for one cycle, captures result and zero, and returns them with a valid/ready handshake.
- Sits between the requesters and the combinational ALU.

Parameters:
WIDTH, 32, operand/result width
CTRL_W, 4, ALU control code width

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  WIDTH  operand A
req0_b  input  WIDTH  operand B
req0_op  input  CTRL_W  ALU control code
resp0_valid  output  1  response for requester 0 available
resp0_ready  input  1  requester 0 consumes response
req1_valid, req1_ready, req1_a, req1_b, req1_op, resp1_valid, resp1_ready  same as requester 0, for requester 1
resp_result  output  WIDTH  result of the completed operation (shared, qualified by respN_valid)
resp_zero  output  1  ALU zero flag of the completed operation
resp_err  output  1  operation had an unsupported op code
alu_a  output  WIDTH  to ALU A
alu_b  output  WIDTH  to ALU B
alu_ctrl  output  CTRL_W  to ALU Control_in
alu_result  input  WIDTH  from ALU_Result
alu_zero  input  1  from ALU zero

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, prio=0.
  - All req*_ready, resp*_valid, resp_zero and resp_err are 0; resp_result=0.
  - alu_a=0, alu_b=0, alu_ctrl=4'b0010.
- Legal op codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB. All others are illegal.
- FSM states:
  - IDLE:
    - reqN_ready is combinational: asserted only for the granted requester, only in IDLE.
    - Grant rule: if only one reqN_valid is high, it is granted. If both are high, the requester equal to prio is granted.
    - On grant: capture a, b, op and the owner id into registers; go to EXEC.
    - If no valid: stay in IDLE; the alu_* registers hold their values.
  - EXEC (1 cycle):
    - alu_a, alu_b and alu_ctrl come from the registers. For an illegal op, alu_ctrl is forced to 4'b0010.
    - At the end of the cycle: resp_result<=alu_result, resp_zero<=alu_zero, resp_err<=0.
    - Illegal op instead gives resp_result<=0, resp_zero<=0, resp_err<=1.
    - Go to RESP.
  - RESP:
    - respN_valid=1 for the owner only. resp_result, resp_zero and resp_err are held stable.
    - When respN_ready is high: respN_valid drops next cycle, prio<=~owner, go to IDLE.
    - While respN_ready stays low, stay in RESP indefinitely. No new request is accepted.
- Latency and throughput:
  - Accept in cycle t, respN_valid high in cycle t+2 (if ready already high, it is consumed at t+2).
  - Minimum 3 cycles per operation; a new accept is possible at t+3.
- Zero flag: passed through exactly as the ALU produces it. It is 1 only for SUB with A==B, 0 for AND/OR/ADD.
- Arithmetic: no extension or saturation; WIDTH-bit wrap-around comes from the ALU.
- Boundary rules:
  - Round-robin only changes prio on response completion, so under continuous contention grants alternate 0,1,0,1.
  - A requester dropping valid before ready is not an error; no grant is given.
  - Requester inputs are ignored outside IDLE.
  - Response data persists after the handshake until the next EXEC overwrites it.
  - reset_n low in any state aborts the in-flight operation immediately: no response is emitted and prio returns to 0.

Test Plan:
- Single ADD: req0 a=5, b=7, op=0010, resp0_ready=1 → req0_ready at t, resp0_valid at t+2, resp_result=12, resp_zero=0, resp_err=0.
- SUB equality and wrap: req1 a=b=0x1234 op=0110 → result 0, zero=1. Then a=0, b=1 → result 0xFFFFFFFF, zero=0.
- Contention: both valid continuously (req0 AND 0xF0&0x3C, req1 OR 0xF0|0x0F) → grants 0,1,0,1; results 0x30 and 0xFF routed only to the owner's respN_valid.
- Backpressure: resp0_ready held low 5 cycles with req1_valid high → resp0_valid and data stable, req1_ready stays 0. Release → req1 granted next IDLE cycle.
- Illegal op 0101 → alu_ctrl=0010 during EXEC, resp_err=1, resp_result=0, resp_zero=0.
- Async reset asserted during EXEC → all outputs at reset values immediately, no respN_valid afterwards, next simultaneous request grants req0.
